// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes, FSM states,
// and parameter legality helpers.
package writeback_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/writeback_unit_load_align.sv
// Load data alignment: shift the raw memory word down by the byte offset,
// then sign- or zero-extend according to the load funct3.
module load_align
  import writeback_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] byte_off,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {byte_off, 3'b000};

  // Keep the low n bits and extend them back to XLEN.
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v,
                                          input int n, input logic sgn);
    logic [XLEN-1:0]        up;
    logic signed [XLEN-1:0] sup;
    up  = v << (XLEN - n);
    sup = $signed(up);
    if (sgn) return $unsigned(sup >>> (XLEN - n));
    return up >> (XLEN - n);
  endfunction

  always_comb begin
    data = shifted;
    case (funct3)
      F3_LB:  data = ext(shifted, 8, 1'b1);
      F3_LH:  data = ext(shifted, 16, 1'b1);
      F3_LW:  data = ext(shifted, 32, 1'b1);
      F3_LBU: data = ext(shifted, 8, 1'b0);
      F3_LHU: data = ext(shifted, 16, 1'b0);
      F3_LWU: if (XLEN == 64) data = ext(shifted, 32, 1'b0);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: trap/mret PC redirect, load alignment, CSR/ALU result
// select, and a stall FSM that waits for the data-memory ack with a timeout.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int MAX_LOAD_WAIT = 16,
  parameter int OFF_W         = $clog2(XLEN/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prev_clk_en,
  input  logic [2:0]            funct3,
  input  logic                  opcode_load,
  input  logic                  opcode_system,
  input  logic [OFF_W-1:0]      load_byte_off,
  input  logic                  dmem_ack,
  input  logic [XLEN-1:0]       dmem_rdata,
  input  logic [XLEN-1:0]       csr_out,
  input  logic                  prev_rd_w_en,
  input  logic [REG_ADDR_W-1:0] prev_rd,
  input  logic [XLEN-1:0]       prev_rd_wdata,
  input  logic [XLEN-1:0]       prev_pc,
  input  logic                  go_to_trap,
  input  logic                  return_from_trap,
  input  logic [XLEN-1:0]       return_addr,
  input  logic [XLEN-1:0]       trap_addr,
  output logic                  rd_w_en,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       rd_wdata,
  output logic [XLEN-1:0]       next_pc,
  output logic                  change_pc,
  output logic                  stall,
  output logic                  flush,
  output logic                  load_fault
);

  localparam int CW = $clog2(MAX_LOAD_WAIT + 1);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("writeback_unit: XLEN must be 32 or 64");
  end
  if (MAX_LOAD_WAIT < 1) begin : g_bad_wait
    $error("writeback_unit: MAX_LOAD_WAIT must be at least 1");
  end

  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] load_data;

  logic trap, load_vld, waiting, at_limit, timeout, stall_int;

  load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .funct3   (funct3),
    .byte_off (load_byte_off),
    .rdata    (dmem_rdata),
    .data     (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    trap     = go_to_trap | return_from_trap;
    load_vld = prev_clk_en & opcode_load;
    waiting  = (state_q == ST_WAIT);
    at_limit = (cnt_q == CW'(MAX_LOAD_WAIT));
    // An ack arriving on the limit cycle still completes the load.
    timeout  = ~trap & waiting & load_vld & ~dmem_ack & at_limit;
    // A WAIT with no valid instruction this cycle keeps the pipe frozen.
    stall_int = ~trap & ((load_vld & ~dmem_ack & ~timeout) |
                         (waiting & ~prev_clk_en));

    state_d = state_q;
    cnt_d   = cnt_q;
    if (trap) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (!waiting) begin
      if (load_vld && !dmem_ack) begin
        state_d = ST_WAIT;
        cnt_d   = CW'(1);
      end
    end else if (prev_clk_en) begin
      if (!opcode_load || dmem_ack || at_limit) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    rd_w_en    = 1'b0;
    rd         = '0;
    rd_wdata   = '0;
    next_pc    = '0;
    change_pc  = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    load_fault = 1'b0;
    if (!rst) begin
      rd         = prev_rd;
      change_pc  = trap;
      flush      = trap & prev_clk_en;
      stall      = stall_int;
      load_fault = timeout;
      if (go_to_trap)            next_pc = trap_addr;
      else if (return_from_trap) next_pc = return_addr;
      else                       next_pc = prev_pc;
      if (load_vld)                              rd_wdata = load_data;
      else if (opcode_system && funct3 != 3'b0) rd_wdata = csr_out;
      else                                       rd_wdata = prev_rd_wdata;
      rd_w_en = prev_rd_w_en & prev_clk_en & ~stall_int & (prev_rd != '0) &
                ~trap & ~timeout;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: behavioural model checked every cycle plus
// directed vectors with hand-computed literal expectations.
module tb_writeback_unit;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int MAXW = 4;
  localparam logic [31:0] RDATA = 32'h80FF7F01;

  logic            clk = 1'b0;
  logic            rst;
  logic            prev_clk_en, opcode_load, opcode_system, dmem_ack;
  logic [2:0]      funct3;
  logic [1:0]      load_byte_off;
  logic [XLEN-1:0] dmem_rdata, csr_out, prev_rd_wdata, prev_pc;
  logic [XLEN-1:0] return_addr, trap_addr;
  logic            prev_rd_w_en, go_to_trap, return_from_trap;
  logic [RW-1:0]   prev_rd;
  logic            rd_w_en, change_pc, stall, flush, load_fault;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] rd_wdata, next_pc;

  int errors = 0;
  int checks = 0;
  int mwait  = 0;   // cycles the current load has already waited for its ack
  int nstall;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(XLEN), .REG_ADDR_W(RW), .MAX_LOAD_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .prev_clk_en(prev_clk_en), .funct3(funct3),
    .opcode_load(opcode_load), .opcode_system(opcode_system),
    .load_byte_off(load_byte_off), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .csr_out(csr_out), .prev_rd_w_en(prev_rd_w_en),
    .prev_rd(prev_rd), .prev_rd_wdata(prev_rd_wdata), .prev_pc(prev_pc),
    .go_to_trap(go_to_trap), .return_from_trap(return_from_trap),
    .return_addr(return_addr), .trap_addr(trap_addr), .rd_w_en(rd_w_en),
    .rd(rd), .rd_wdata(rd_wdata), .next_pc(next_pc), .change_pc(change_pc),
    .stall(stall), .flush(flush), .load_fault(load_fault)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load result from plain byte/halfword arithmetic on the shifted word.
  function automatic logic [31:0] m_align(input logic [2:0] f,
                                          input logic [1:0] off,
                                          input logic [31:0] d);
    logic [31:0] w;
    logic [31:0] b, h;
    w = d >> (32'(off) * 8);
    b = w % 256;
    h = w % 65536;
    case (f)
      3'd0: return (b >= 128) ? b - 256 : b;
      3'd1: return (h >= 32768) ? h - 65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    logic t, ld, fault, st, wen;
    logic [31:0] wd, pc;
    t     = go_to_trap | return_from_trap;
    ld    = prev_clk_en & opcode_load;
    fault = !t && ld && !dmem_ack && mwait == MAXW;
    st    = !t && ((ld && !dmem_ack && !fault) || (!prev_clk_en && mwait > 0));
    wen   = prev_rd_w_en && prev_clk_en && !st && prev_rd != 0 && !t && !fault;
    pc    = go_to_trap ? trap_addr : return_from_trap ? return_addr : prev_pc;
    if (ld) wd = m_align(funct3, load_byte_off, dmem_rdata);
    else if (opcode_system && funct3 != 0) wd = csr_out;
    else wd = prev_rd_wdata;
    if (rst) begin
      {t, fault, st, wen} = '0;
      wd = '0;
      pc = '0;
    end
    chk("m_rd_w_en", rd_w_en, wen);
    chk("m_rd", rd, rst ? '0 : prev_rd);
    chk("m_rd_wdata", rd_wdata, wd);
    chk("m_next_pc", next_pc, pc);
    chk("m_change_pc", change_pc, t);
    chk("m_stall", stall, st);
    chk("m_flush", flush, !rst && t && prev_clk_en);
    chk("m_load_fault", load_fault, fault);
  end

  always @(posedge clk) begin
    if (rst || go_to_trap || return_from_trap) mwait <= 0;
    else if (prev_clk_en) begin
      if (!opcode_load || dmem_ack || mwait == MAXW) mwait <= 0;
      else mwait <= mwait + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    prev_clk_en = 0; opcode_load = 0; opcode_system = 0; dmem_ack = 0;
    funct3 = 0; load_byte_off = 0; dmem_rdata = RDATA; csr_out = 0;
    prev_rd_w_en = 0; prev_rd = 0; prev_rd_wdata = 0; prev_pc = 32'h1000;
    go_to_trap = 0; return_from_trap = 0; return_addr = 0; trap_addr = 0;
  endtask

  task automatic load(input logic [2:0] f, input logic [1:0] off,
                      input logic ack);
    prev_clk_en = 1; opcode_load = 1; funct3 = f; load_byte_off = off;
    dmem_ack = ack; dmem_rdata = RDATA; prev_rd_w_en = 1; prev_rd = 7;
  endtask

  logic [2:0]  al_f[6]   = '{3'd1, 3'd1, 3'd4, 3'd2, 3'd0, 3'd7};
  logic [1:0]  al_o[6]   = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1};
  logic [31:0] al_e[6]   = '{32'h00007F01, 32'hFFFF80FF, 32'h0000007F,
                             32'h80FF7F01, 32'h0000007F, 32'h0080FF7F};

  initial begin
    clear();
    rst = 1; prev_clk_en = 1; prev_rd_w_en = 1; prev_rd = 3;
    prev_rd_wdata = 32'h55; go_to_trap = 1; trap_addr = 32'h44;
    cyc(); #3;
    chk("reset_rd_w_en", rd_w_en, 0);
    chk("reset_change_pc", change_pc, 0);
    chk("reset_next_pc", next_pc, 0);
    chk("reset_rd", rd, 0);
    cyc(); rst = 0; clear();

    // LB offset 3, immediate ack
    load(3'd0, 2'd3, 1'b1); #3;
    chk("lb_wdata", rd_wdata, 32'hFFFFFF80);
    chk("lb_wen", rd_w_en, 1);
    chk("lb_stall", stall, 0);
    cyc();

    // LHU offset 2, ack three cycles later
    load(3'd5, 2'd2, 1'b0); nstall = 0;
    repeat (3) begin #3; if (stall) nstall++; chk("lhu_wait_wen", rd_w_en, 0); cyc(); end
    dmem_ack = 1; #3;
    chk("lhu_stall_cycles", nstall, 3);
    chk("lhu_wdata", rd_wdata, 32'h000080FF);
    chk("lhu_wen", rd_w_en, 1);
    chk("lhu_stall_done", stall, 0);
    cyc(); clear(); #3; chk("lhu_after_stall", stall, 0); cyc();

    // timeout with no ack
    load(3'd2, 2'd0, 1'b0);
    repeat (4) begin #3; chk("to_no_fault_yet", load_fault, 0); cyc(); end
    #3;
    chk("to_fault", load_fault, 1);
    chk("to_stall", stall, 0);
    chk("to_wen", rd_w_en, 0);
    cyc(); clear(); #3; chk("to_fault_once", load_fault, 0); cyc();

    // ack on the limit cycle wins over the timeout
    load(3'd2, 2'd0, 1'b0); repeat (4) cyc();
    dmem_ack = 1; #3;
    chk("lim_ack_fault", load_fault, 0);
    chk("lim_ack_wen", rd_w_en, 1);
    cyc(); clear(); cyc();

    // prev_clk_en low during WAIT keeps the stall
    load(3'd4, 2'd1, 1'b0); cyc();
    prev_clk_en = 0; #3; chk("hold_stall", stall, 1); cyc(); cyc();
    prev_clk_en = 1; dmem_ack = 1; #3;
    chk("hold_wdata", rd_wdata, 32'h7F);
    chk("hold_wen", rd_w_en, 1);
    cyc(); clear(); cyc();

    // trap during WAIT
    load(3'd0, 2'd0, 1'b0); cyc(); cyc();
    go_to_trap = 1; trap_addr = 32'h100; #3;
    chk("trap_change_pc", change_pc, 1);
    chk("trap_next_pc", next_pc, 32'h100);
    chk("trap_flush", flush, 1);
    chk("trap_wen", rd_w_en, 0);
    cyc();
    go_to_trap = 0; prev_clk_en = 0; dmem_ack = 1; #3;
    chk("trap_left_wait", stall, 0);
    chk("trap_late_ack_wen", rd_w_en, 0);
    cyc(); clear();

    // mret with no valid instruction: redirect, no flush
    return_from_trap = 1; return_addr = 32'h200; #3;
    chk("mret_next_pc", next_pc, 32'h200);
    chk("mret_flush", flush, 0);
    cyc(); clear();

    // CSR read into x0 then x5
    prev_clk_en = 1; opcode_system = 1; funct3 = 3'd1; csr_out = 32'h1234;
    prev_rd_w_en = 1; prev_rd = 0; #3;
    chk("csr_x0_wen", rd_w_en, 0);
    cyc(); prev_rd = 5; #3;
    chk("csr_wen", rd_w_en, 1);
    chk("csr_wdata", rd_wdata, 32'h1234);
    chk("csr_rd", rd, 5);
    cyc(); clear();

    // plain ALU result
    prev_clk_en = 1; prev_rd_w_en = 1; prev_rd = 9;
    prev_rd_wdata = 32'hDEADBEEF; prev_pc = 32'h80; #3;
    chk("alu_wdata", rd_wdata, 32'hDEADBEEF);
    chk("alu_next_pc", next_pc, 32'h80);
    cyc(); clear();

    for (int i = 0; i < 6; i++) begin
      load(al_f[i], al_o[i], 1'b1); #3;
      chk($sformatf("align_%0d", i), rd_wdata, al_e[i]);
      cyc();
    end
    clear(); cyc();

    // reset in the middle of WAIT
    load(3'd0, 2'd0, 1'b0); cyc(); cyc();
    rst = 1; #3;
    chk("rst_wait_stall", stall, 0);
    chk("rst_wait_rd", rd, 0);
    chk("rst_wait_fault", load_fault, 0);
    cyc(); rst = 0; clear(); #3;
    chk("rst_after_fault", load_fault, 0);
    chk("rst_after_stall", stall, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
